// File: rtl/registro_resultado_alu.sv
// registro_resultado_alu: captures one ALU unit's result and flags on load and
// shows them on two multiplexed active-low 7-segment digits (sign + value).
module registro_resultado_alu #(
    parameter int WIDTH       = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel_op,
    input  logic             load,
    input  logic [WIDTH-1:0] y_mul,
    input  logic [3:0]       flags_mul,
    input  logic [WIDTH-1:0] y_res,
    input  logic [3:0]       flags_res,
    output logic [WIDTH-1:0] y_q,
    output logic [3:0]       flags_q,
    output logic             op_q,
    output logic             valido,
    output logic [6:0]       seg,
    output logic [1:0]       an
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [CW-1:0]    cnt;
    logic             dig;
    logic             wrap;
    logic             neg;
    logic [WIDTH-1:0] mag;
    assign wrap = cnt == CW'(REFRESH_DIV - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            flags_q <= '0;
            op_q    <= 1'b0;
            valido  <= 1'b0;
            cnt     <= '0;
            dig     <= 1'b0;
        end else begin
            if (load) begin
                y_q     <= sel_op ? y_res : y_mul;
                flags_q <= sel_op ? flags_res : flags_mul;
                op_q    <= sel_op;
                valido  <= 1'b1;
            end
            cnt <= wrap ? '0 : cnt + CW'(1);
            dig <= wrap ? ~dig : dig;
        end
    end
    // Only a restador result with N set is displayed as sign + magnitude.
    always_comb begin
        neg = op_q & flags_q[2];
        mag = neg ? -y_q : y_q;
        an  = dig ? 2'b01 : 2'b10;
        seg = dig ? (neg ? 7'b0111111 : 7'b1111111) : GLYPH[mag];
    end
endmodule
